mem_bus_arb: RTL and testbench
==============================

// Module: mem_bus_arb
// PURPOSE
//  Shares one instruction/data memory bus port between the fetch unit (PC fetch) and the load/store unit.
//  Fixed priority LSU > IFU, with an anti-starvation counter that forces an IFU win.
//  One outstanding transaction; drives a stall request to ctrl while a fetch is pending.
//  Drops fetch responses killed by a jump or exception flush.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width (byte enables are DW/8 wide)
//  STARVE_MAX  4   consecutive LSU wins while IFU waits before IFU is forced to win (>=1)
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      reset; asynchronous, active-low
//  ifu_req_i     in   1      fetch request, held until ifu_gnt_o
//  ifu_addr_i    in   AW     fetch address (PC)
//  ifu_gnt_o     out  1      fetch request accepted by arbiter
//  ifu_rvalid_o  out  1      one-cycle pulse: fetched instruction valid
//  ifu_rdata_o   out  DW     fetched instruction
//  lsu_req_i     in   1      data request, held until lsu_gnt_o
//  lsu_we_i      in   1      1 = store
//  lsu_be_i      in   DW/8   byte enables
//  lsu_addr_i    in   AW     data address
//  lsu_wdata_i   in   DW     store data
//  lsu_gnt_o     out  1      data request accepted by arbiter
//  lsu_rvalid_o  out  1      one-cycle pulse: load data or store ack
//  lsu_rdata_o   out  DW     load data
//  flush_i       in   1      jump/exception redirect; kills the in-flight fetch response
//  stall_req_o   out  1      to ctrl: fetch waiting (stalls IFU PC advance)
//  bus_req_o     out  1      bus request; held until bus_gnt_i
//  bus_we_o      out  1      / bus_be_o DW/8, bus_addr_o AW, bus_wdata_o DW: latched request fields
//  bus_gnt_i     in   1      bus accepted the address phase
//  bus_rvalid_i  in   1      bus response valid
//  bus_rdata_i   in   DW     bus response data
// BEHAVIOUR
//  FSM states: IDLE, REQ, RESP.
//  - IDLE: if lsu_req_i or ifu_req_i, arbitrate:
//    - pick the winner; pulse its *_gnt_o combinationally this cycle.
//    - latch owner, addr, we, be and wdata; go to REQ.
//    - IFU fields: we=0, be=all-ones.
//  - Arbitration: LSU wins unless starve_cnt==STARVE_MAX, then IFU wins.
//  - starve_cnt: +1 on an LSU win while ifu_req_i=1 (saturates).
//    Cleared on an IFU win, or in any IDLE cycle with ifu_req_i=0.
//  - REQ: bus_req_o=1 with latched fields stable; on bus_gnt_i go to RESP.
//    Bus fields must not change while bus_req_o=1 and bus_gnt_i=0.
//  - RESP: bus_req_o=0; on bus_rvalid_i go to IDLE.
//    - Pulse owner rvalid_o one cycle; rdata_o = bus_rdata_i (registered, 1-cycle latency).
//    - rvalid_o arrives the cycle after bus_rvalid_i.
//  - Minimum latency: req (IDLE) -> bus_req_o next cycle -> gnt -> rvalid -> *_rvalid_o.
//    One IDLE bubble between back-to-back transactions.
//  - rdata outputs hold their last value; default 0.
//  - flush_i while owner=IFU in REQ/RESP: set drop.
//    - The transaction still completes on the bus; ifu_rvalid_o is suppressed.
//    - drop clears when going to IDLE.
//    - flush_i in the same cycle as bus_rvalid_i also suppresses.
//  - flush_i in IDLE with ifu_req_i=1: the request is accepted normally (it is the redirect PC).
//    flush_i never affects LSU transactions.
//  - bus_rvalid_i in IDLE/REQ and bus_gnt_i outside REQ are ignored.
//  - stall_req_o = (ifu_req_i & ~ifu_gnt_o) | (owner==IFU & state!=IDLE & ~drop).
//  - Reset (any time, incl. mid-transaction): state IDLE, all outputs 0, starve_cnt 0, drop 0, owner LSU.
// TESTING
//  1. IFU alone: addr 0x0000_0000, bus_gnt_i same cycle as bus_req_o, rvalid next cycle with 0x0000_0013.
//     -> ifu_rvalid_o pulses once with ifu_rdata_o=0x13.
//  2. IFU and LSU request the same cycle (LSU load 0x100).
//     -> lsu_gnt_o=1, ifu_gnt_o=0, stall_req_o=1; IFU granted in the first IDLE after the LSU response.
//  3. STARVE_MAX=4, both requesting continuously -> 4 LSU grants, then 1 IFU grant, then LSU again.
//  4. flush_i during IFU RESP -> bus completes, ifu_rvalid_o stays 0, stall_req_o drops; next fetch served normally.
//  5. LSU store, bus_gnt_i delayed 3 cycles -> bus_req_o high 4 cycles.
//     -> addr/we=1/be=0xF/wdata 0xDEADBEEF stable; lsu_rvalid_o after rvalid.
//  6. rst_n asserted in RESP, then a stray bus_rvalid_i after release -> all outputs 0, no rvalid pulse, state IDLE.

Source files
------------

// File: rtl/mem_bus_arb_if.sv
// rtl/mem_bus_arb_if.sv - fetch/LSU/bus signal bundle for the memory bus arbiter

interface mem_bus_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              ifu_req;
    logic [AW-1:0]     ifu_addr;
    logic              ifu_gnt;
    logic              ifu_rvalid;
    logic [DW-1:0]     ifu_rdata;

    logic              lsu_req;
    logic              lsu_we;
    logic [DW/8-1:0]   lsu_be;
    logic [AW-1:0]     lsu_addr;
    logic [DW-1:0]     lsu_wdata;
    logic              lsu_gnt;
    logic              lsu_rvalid;
    logic [DW-1:0]     lsu_rdata;

    logic              flush;
    logic              stall_req;

    logic              bus_req;
    logic              bus_we;
    logic [DW/8-1:0]   bus_be;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [DW-1:0]     bus_rdata;

    // Arbiter side
    modport slave (
        input  ifu_req, ifu_addr,
        output ifu_gnt, ifu_rvalid, ifu_rdata,
        input  lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
        output lsu_gnt, lsu_rvalid, lsu_rdata,
        input  flush,
        output stall_req,
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    // Requester and memory side
    modport master (
        output ifu_req, ifu_addr,
        input  ifu_gnt, ifu_rvalid, ifu_rdata,
        output lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
        input  lsu_gnt, lsu_rvalid, lsu_rdata,
        output flush,
        input  stall_req,
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_bus_arb.sv
// rtl/mem_bus_arb.sv - LSU-over-IFU memory bus arbiter with anti-starvation and fetch flush

module mem_bus_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_bus_arb_if.slave  port
);
    localparam int BW = DW / 8;
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t          state_q, state_d;
    logic            owner_ifu_q;
    logic            drop_q;
    logic [CW-1:0]   starve_q;
    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [BW-1:0]   be_q;
    logic [DW-1:0]   wdata_q;
    logic            ifu_rvalid_q, lsu_rvalid_q;
    logic [DW-1:0]   ifu_rdata_q, lsu_rdata_q;

    logic            idle;
    logic            ifu_win, lsu_win;
    logic            resp_fire;
    logic            ifu_deliver;

    always_comb begin
        idle        = (state_q == S_IDLE);
        ifu_win     = idle & port.ifu_req & (~port.lsu_req | (starve_q == STARVE_LIM));
        lsu_win     = idle & port.lsu_req & ~ifu_win;
        resp_fire   = (state_q == S_RESP) & port.bus_rvalid;
        // A flush arriving with the response still kills it
        ifu_deliver = resp_fire & owner_ifu_q & ~drop_q & ~port.flush;

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ifu_win | lsu_win) state_d = S_REQ;
            S_REQ:   if (port.bus_gnt)      state_d = S_RESP;
            S_RESP:  if (port.bus_rvalid)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_ifu_q  <= 1'b0;
            drop_q       <= 1'b0;
            starve_q     <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            if (ifu_win) begin
                owner_ifu_q <= 1'b1;
                addr_q      <= port.ifu_addr;
                we_q        <= 1'b0;
                be_q        <= '1;
                wdata_q     <= '0;
            end else if (lsu_win) begin
                owner_ifu_q <= 1'b0;
                addr_q      <= port.lsu_addr;
                we_q        <= port.lsu_we;
                be_q        <= port.lsu_be;
                wdata_q     <= port.lsu_wdata;
            end

            // Counts LSU wins that left a waiting fetch behind
            if (idle) begin
                if (ifu_win || !port.ifu_req)
                    starve_q <= '0;
                else if (lsu_win && starve_q != STARVE_LIM)
                    starve_q <= starve_q + 1'b1;
            end

            if (state_d == S_IDLE)
                drop_q <= 1'b0;
            else if (!idle && owner_ifu_q && port.flush)
                drop_q <= 1'b1;

            ifu_rvalid_q <= ifu_deliver;
            lsu_rvalid_q <= resp_fire & ~owner_ifu_q;
            if (ifu_deliver)
                ifu_rdata_q <= port.bus_rdata;
            if (resp_fire && !owner_ifu_q)
                lsu_rdata_q <= port.bus_rdata;
        end
    end

    assign port.ifu_gnt    = ifu_win;
    assign port.lsu_gnt    = lsu_win;
    assign port.ifu_rvalid = ifu_rvalid_q;
    assign port.ifu_rdata  = ifu_rdata_q;
    assign port.lsu_rvalid = lsu_rvalid_q;
    assign port.lsu_rdata  = lsu_rdata_q;
    assign port.stall_req  = (port.ifu_req & ~ifu_win) | (owner_ifu_q & ~idle & ~drop_q);
    assign port.bus_req    = (state_q == S_REQ);
    assign port.bus_we     = we_q;
    assign port.bus_be     = be_q;
    assign port.bus_addr   = addr_q;
    assign port.bus_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_bus_arb.sv
// tb/tb_mem_bus_arb.sv - directed self-checking bench for mem_bus_arb

module tb_mem_bus_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_bus_arb_if #(.AW(32), .DW(32)) bus ();

    mem_bus_arb #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .port  (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus.ifu_req = 0; bus.ifu_addr = '0;
        bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_be = '0; bus.lsu_addr = '0; bus.lsu_wdata = '0;
        bus.flush = 0; bus.bus_gnt = 0; bus.bus_rvalid = 0; bus.bus_rdata = '0;

        repeat (3) cyc();
        check("rst_bus_req", bus.bus_req, 0);
        check("rst_stall", bus.stall_req, 0);
        check("rst_ifu_rvalid", bus.ifu_rvalid, 0);
        check("rst_lsu_rvalid", bus.lsu_rvalid, 0);
        check("rst_bus_addr", bus.bus_addr, 0);
        check("rst_ifu_rdata", bus.ifu_rdata, 0);
        rst_n = 1;
        cyc();

        // 1: lone fetch, minimum latency
        bus.ifu_req = 1; bus.ifu_addr = 32'h0; settle();
        check("t1_ifu_gnt", bus.ifu_gnt, 1);
        check("t1_bus_req_idle", bus.bus_req, 0);
        cyc(); bus.ifu_req = 0; bus.bus_gnt = 1; settle();
        check("t1_bus_req", bus.bus_req, 1);
        check("t1_bus_addr", bus.bus_addr, 32'h0);
        check("t1_bus_we", bus.bus_we, 0);
        check("t1_bus_be", bus.bus_be, 4'hF);
        check("t1_stall", bus.stall_req, 1);
        cyc(); bus.bus_gnt = 0; bus.bus_rvalid = 1; bus.bus_rdata = 32'h0000_0013; settle();
        check("t1_bus_req_resp", bus.bus_req, 0);
        check("t1_rvalid_early", bus.ifu_rvalid, 0);
        cyc(); bus.bus_rvalid = 0; settle();
        check("t1_ifu_rvalid", bus.ifu_rvalid, 1);
        check("t1_ifu_rdata", bus.ifu_rdata, 32'h13);
        check("t1_stall_done", bus.stall_req, 0);
        cyc();
        check("t1_rvalid_pulse", bus.ifu_rvalid, 0);

        // 2: simultaneous requests, LSU first
        bus.ifu_req = 1; bus.ifu_addr = 32'h4;
        bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_be = 4'hF; bus.lsu_addr = 32'h100; settle();
        check("t2_lsu_gnt", bus.lsu_gnt, 1);
        check("t2_ifu_gnt", bus.ifu_gnt, 0);
        check("t2_stall", bus.stall_req, 1);
        cyc(); bus.lsu_req = 0; bus.bus_gnt = 1; settle();
        check("t2_bus_addr", bus.bus_addr, 32'h100);
        check("t2_ifu_gnt_req", bus.ifu_gnt, 0);
        check("t2_stall_req", bus.stall_req, 1);
        cyc(); bus.bus_gnt = 0; bus.bus_rvalid = 1; bus.bus_rdata = 32'h0000_AA55; settle();
        check("t2_ifu_gnt_resp", bus.ifu_gnt, 0);
        cyc(); bus.bus_rvalid = 0; settle();
        check("t2_lsu_rvalid", bus.lsu_rvalid, 1);
        check("t2_lsu_rdata", bus.lsu_rdata, 32'hAA55);
        check("t2_ifu_gnt_idle", bus.ifu_gnt, 1);
        cyc(); bus.ifu_req = 0; bus.bus_gnt = 1; settle();
        check("t2_bus_addr_ifu", bus.bus_addr, 32'h4);
        cyc(); bus.bus_gnt = 0; bus.bus_rvalid = 1; bus.bus_rdata = 32'h0040_0093; settle();
        cyc(); bus.bus_rvalid = 0; settle();
        check("t2_ifu_rvalid", bus.ifu_rvalid, 1);
        check("t2_ifu_rdata", bus.ifu_rdata, 32'h0040_0093);

        // 3: continuous contention -> four LSU wins, one forced IFU win, then LSU
        cyc();
        bus.ifu_req = 1; bus.lsu_req = 1; bus.lsu_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            logic exp_ifu;
            exp_ifu = (i == 4);
            settle();
            check($sformatf("t3_ifu_gnt_%0d", i), bus.ifu_gnt, exp_ifu);
            check($sformatf("t3_lsu_gnt_%0d", i), bus.lsu_gnt, !exp_ifu);
            cyc(); bus.bus_gnt = 1;
            if (i == 5) begin bus.ifu_req = 0; bus.lsu_req = 0; end
            cyc(); bus.bus_gnt = 0; bus.bus_rvalid = 1; bus.bus_rdata = 32'(i);
            cyc(); bus.bus_rvalid = 0; settle();
            check($sformatf("t3_ifu_rvalid_%0d", i), bus.ifu_rvalid, exp_ifu);
            check($sformatf("t3_lsu_rvalid_%0d", i), bus.lsu_rvalid, !exp_ifu);
        end

        // 4: flush kills an in-flight fetch response
        cyc();
        bus.ifu_req = 1; bus.ifu_addr = 32'h300; settle();
        check("t4_ifu_gnt", bus.ifu_gnt, 1);
        cyc(); bus.ifu_req = 0; bus.bus_gnt = 1;
        cyc(); bus.bus_gnt = 0; bus.flush = 1; settle();
        check("t4_stall_pre", bus.stall_req, 1);
        cyc(); bus.flush = 0; settle();
        check("t4_stall_drop", bus.stall_req, 0);
        bus.bus_rvalid = 1; bus.bus_rdata = 32'h0000_0BAD;
        cyc(); bus.bus_rvalid = 0; settle();
        check("t4_ifu_rvalid_killed", bus.ifu_rvalid, 0);
        check("t4_state_idle", bus.bus_req, 0);
        // redirect fetch issued alongside flush in IDLE is served normally
        bus.ifu_req = 1; bus.ifu_addr = 32'h400; bus.flush = 1; settle();
        check("t4_redirect_gnt", bus.ifu_gnt, 1);
        cyc(); bus.ifu_req = 0; bus.flush = 0; bus.bus_gnt = 1; settle();
        check("t4_redirect_addr", bus.bus_addr, 32'h400);
        cyc(); bus.bus_gnt = 0; bus.bus_rvalid = 1; bus.bus_rdata = 32'h0000_0517;
        cyc(); bus.bus_rvalid = 0; settle();
        check("t4_redirect_rvalid", bus.ifu_rvalid, 1);
        check("t4_redirect_rdata", bus.ifu_rdata, 32'h0517);

        // 5: store with grant held off three cycles
        cyc();
        bus.lsu_req = 1; bus.lsu_we = 1; bus.lsu_be = 4'hF;
        bus.lsu_addr = 32'h0000_1000; bus.lsu_wdata = 32'hDEAD_BEEF; settle();
        check("t5_lsu_gnt", bus.lsu_gnt, 1);
        cyc();
        bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_be = 4'h1;
        bus.lsu_addr = 32'hFFFF_FFFF; bus.lsu_wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            bus.bus_gnt = (k == 3); settle();
            check($sformatf("t5_bus_req_%0d", k), bus.bus_req, 1);
            check($sformatf("t5_addr_%0d", k), bus.bus_addr, 32'h1000);
            check($sformatf("t5_we_%0d", k), bus.bus_we, 1);
            check($sformatf("t5_be_%0d", k), bus.bus_be, 4'hF);
            check($sformatf("t5_wdata_%0d", k), bus.bus_wdata, 32'hDEAD_BEEF);
            cyc();
        end
        bus.bus_gnt = 0; settle();
        check("t5_bus_req_off", bus.bus_req, 0);
        bus.bus_rvalid = 1; bus.bus_rdata = 32'h0;
        cyc(); bus.bus_rvalid = 0; settle();
        check("t5_lsu_rvalid", bus.lsu_rvalid, 1);
        check("t5_ifu_rvalid", bus.ifu_rvalid, 0);

        // 6: reset mid-response, then a stray response after release
        cyc();
        bus.ifu_req = 1; bus.ifu_addr = 32'h500;
        cyc(); bus.ifu_req = 0; bus.bus_gnt = 1;
        cyc(); bus.bus_gnt = 0; settle();
        check("t6_stall_resp", bus.stall_req, 1);
        rst_n = 0; settle();
        check("t6_stall_rst", bus.stall_req, 0);
        check("t6_lsu_rdata_rst", bus.lsu_rdata, 0);
        cyc(); rst_n = 1; bus.bus_rvalid = 1; bus.bus_rdata = 32'h5555_5555;
        cyc(); bus.bus_rvalid = 0; settle();
        check("t6_ifu_rvalid", bus.ifu_rvalid, 0);
        check("t6_lsu_rvalid", bus.lsu_rvalid, 0);
        check("t6_ifu_rdata", bus.ifu_rdata, 0);
        check("t6_bus_req", bus.bus_req, 0);
        check("t6_bus_addr", bus.bus_addr, 0);
        bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 32'h600; settle();
        check("t6_idle_gnt", bus.lsu_gnt, 1);
        cyc(); bus.lsu_req = 0; bus.bus_gnt = 1; settle();
        check("t6_bus_req_after", bus.bus_req, 1);
        cyc(); bus.bus_gnt = 0; bus.bus_rvalid = 1; bus.bus_rdata = 32'h1234_5678;
        cyc(); bus.bus_rvalid = 0; settle();
        check("t6_lsu_rvalid_after", bus.lsu_rvalid, 1);
        check("t6_lsu_rdata_after", bus.lsu_rdata, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
